// File: rtl/ring_eject_sink.sv
// Ejection-port sink for one ring node. It buffers incoming packets, drains them at a
// throttled rate, and keeps delivery statistics plus a sticky done flag.
module ring_eject_sink #(
   parameter int NODE_ID          = 0,
   parameter int NUM_NODES        = 4,
   parameter int PACKET_SIZE      = 49,
   parameter int BUFFER_SIZE      = 4,
   parameter int DRAIN_CYCLE      = 2,
   parameter int EXPECTED_PACKETS = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PACKET_SIZE-1:0] pkt_in,
   output logic                   in_ready,
   output logic [15:0]            rx_count,
   output logic [15:0]            err_count,
   output logic [31:0]            lat_sum,
   output logic [15:0]            lat_max,
   output logic [15:0]            last_src,
   output logic                   done
);
   localparam int AW         = $clog2(BUFFER_SIZE);
   localparam int GW         = $clog2(DRAIN_CYCLE + 1);
   localparam int GAP_LAST_I = (DRAIN_CYCLE > 1) ? DRAIN_CYCLE - 2 : 0;
   localparam logic [AW:0]   DEPTH    = BUFFER_SIZE[AW:0];
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [47:0]   mem_q [BUFFER_SIZE];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   cycle_cnt_q, cycle_cnt_d;
   logic [15:0]   rx_q, rx_d, err_q, err_d, max_q, max_d, src_q, src_d;
   logic [31:0]   sum_q, sum_d;
   logic          done_q, done_d;

   logic          push, pop, good;
   logic [47:0]   head;
   logic [15:0]   latency;
   logic [32:0]   sum_ext;
   logic [16:0]   total_d;

   // Readiness uses pre-pop occupancy, so a full FIFO frees a slot one edge after the pop.
   assign in_ready = (count_q < DEPTH);
   assign push     = pkt_in[48] && in_ready;
   assign pop      = (state_q == S_POP);
   assign head     = mem_q[rd_ptr_q];
   assign latency  = cycle_cnt_q - head[47:32];
   assign good     = (head[15:0] == 16'(NODE_ID)) && ({16'd0, head[31:16]} < 32'(NUM_NODES)) && !done_q;
   assign sum_ext  = {1'b0, sum_q} + {17'd0, latency};

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cycle_cnt_d = cycle_cnt_q + 16'd1;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: if (count_q != '0) state_d = S_POP;
         S_POP: begin
            if (DRAIN_CYCLE > 1) begin
               state_d = S_GAP;
               gap_d   = '0;
            end else begin
               state_d = (count_q > (AW+1)'(1)) ? S_POP : S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = (count_q != '0) ? S_POP : S_IDLE;
            else                   gap_d   = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_d  = rx_q;
      err_d = err_q;
      sum_d = sum_q;
      max_d = max_q;
      src_d = src_q;
      if (pop) begin
         if (good) begin
            rx_d  = (rx_q == 16'hFFFF) ? rx_q : rx_q + 16'd1;
            sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            max_d = (latency > max_q) ? latency : max_q;
            src_d = head[31:16];
         end else begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
         end
      end
      total_d = {1'b0, rx_d} + {1'b0, err_d};
      done_d  = done_q || (pop && (total_d >= 17'(EXPECTED_PACKETS)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         gap_q       <= '0;
         cycle_cnt_q <= '0;
         rx_q        <= '0;
         err_q       <= '0;
         sum_q       <= '0;
         max_q       <= '0;
         src_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         gap_q       <= gap_d;
         cycle_cnt_q <= cycle_cnt_d;
         rx_q        <= rx_d;
         err_q       <= err_d;
         sum_q       <= sum_d;
         max_q       <= max_d;
         src_q       <= src_d;
         done_q      <= done_d;
      end
   end

   // Storage needs no reset: pointers and occupancy define what is live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pkt_in[47:0];
   end

   assign rx_count  = rx_q;
   assign err_count = err_q;
   assign lat_sum   = sum_q;
   assign lat_max   = max_q;
   assign last_src  = src_q;
   assign done      = done_q;
endmodule

// File: tb/tb_ring_eject_sink.sv
// Bench for ring_eject_sink: accepted packets queue their expected outcome, and each
// observed pop is scored against a reference latency/statistics model.
module tb_ring_eject_sink;
   localparam int BUF = 4;
   localparam int EXP = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [48:0] pkt_in = '0;
   logic        in_ready, done;
   logic [15:0] rx_count, err_count, lat_max, last_src;
   logic [31:0] lat_sum;

   ring_eject_sink #(
      .NODE_ID(3), .NUM_NODES(4), .PACKET_SIZE(49), .BUFFER_SIZE(BUF),
      .DRAIN_CYCLE(2), .EXPECTED_PACKETS(EXP)
   ) dut (
      .clk(clk), .rst(rst), .pkt_in(pkt_in), .in_ready(in_ready),
      .rx_count(rx_count), .err_count(err_count), .lat_sum(lat_sum),
      .lat_max(lat_max), .last_src(last_src), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        good;
      logic [15:0] ts;
      logic [15:0] src;
   } exp_t;

   exp_t        sb[$];
   int          pop_cyc[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] tb_cyc = '0;
   int          m_acc = 0;
   logic [15:0] m_rx = '0, m_err = '0, m_max = '0, m_src = '0;
   logic [31:0] m_sum = '0;
   bit          saw_full = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: record acceptance, then at the falling edge score any pop and check outputs.
   task automatic tick(output bit acc);
      exp_t        e;
      logic [15:0] lat;
      logic [16:0] tot, mtot;
      acc = pkt_in[48] && in_ready && !rst;
      @(posedge clk);
      if (rst) begin
         tb_cyc = '0;
         sb.delete();
         pop_cyc.delete();
         m_acc = 0;
         m_rx = '0; m_err = '0; m_max = '0; m_src = '0; m_sum = '0;
      end else begin
         tb_cyc++;
         if (acc) begin
            e.good = (pkt_in[15:0] == 16'd3) && (pkt_in[31:16] < 16'd4) && (m_acc < EXP);
            e.ts   = pkt_in[47:32];
            e.src  = pkt_in[31:16];
            sb.push_back(e);
            m_acc++;
         end
      end
      @(negedge clk);
      tot  = {1'b0, rx_count} + {1'b0, err_count};
      mtot = {1'b0, m_rx} + {1'b0, m_err};
      if (tot != mtot) begin
         chk("pop_step", 32'(tot), 32'(mtot) + 32'd1);
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            lat = tb_cyc - 16'd1 - e.ts;
            if (e.good) begin
               m_rx++;
               m_sum = m_sum + {16'd0, lat};
               if (lat > m_max) m_max = lat;
               m_src = e.src;
            end else begin
               m_err++;
            end
            pop_cyc.push_back(int'(tb_cyc));
         end
      end
      mtot = {1'b0, m_rx} + {1'b0, m_err};
      if (!in_ready) saw_full = 1'b1;
      chk("rx_count",  32'(rx_count),  32'(m_rx));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("lat_sum",   lat_sum,        m_sum);
      chk("lat_max",   32'(lat_max),   32'(m_max));
      chk("last_src",  32'(last_src),  32'(m_src));
      chk("done",      32'(done),      32'(mtot >= 17'(EXP)));
      chk("in_ready",  32'(in_ready),  32'(sb.size() < BUF));
   endtask

   task automatic do_reset();
      bit a;
      rst = 1'b1;
      pkt_in = '0;
      tick(a);
      tick(a);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      pkt_in = '0;
      repeat (n) tick(a);
   endtask

   task automatic send(input logic [15:0] ts, input logic [15:0] src, input logic [15:0] dst);
      bit a;
      int k;
      pkt_in = {1'b1, ts, src, dst};
      a = 1'b0;
      k = 0;
      while (!a && k < 50) begin
         tick(a);
         k++;
      end
      chk("accept", 32'(a), 32'd1);
   endtask

   task automatic drain();
      bit a;
      int k;
      pkt_in = '0;
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         tick(a);
         k++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      idle(3);
   endtask

   initial begin
      bit a;
      int k;

      // Reset state
      do_reset();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rx", 32'(rx_count), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_sum", lat_sum, 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Accepted at cycle_cnt=10, ts=5: visible after edge 12 with latency 7
      pkt_in = '0;
      k = 0;
      while (tb_cyc != 16'd10 && k < 50) begin
         tick(a);
         k++;
      end
      chk("t1_cyc", 32'(tb_cyc), 32'd10);
      pkt_in = {1'b1, 16'd5, 16'd0, 16'd3};
      tick(a);
      chk("t1_acc", 32'(a), 32'd1);
      pkt_in = '0;
      tick(a);
      chk("t1_not_yet", 32'(rx_count), 32'd0);
      tick(a);
      chk("t1_rx", 32'(rx_count), 32'd1);
      chk("t1_sum", lat_sum, 32'd7);
      chk("t1_max", 32'(lat_max), 32'd7);
      chk("t1_src", 32'(last_src), 32'd0);

      // Wrong destination, then out-of-range source
      do_reset();
      send(16'd1, 16'd0, 16'd2);
      send(16'd2, 16'd7, 16'd3);
      drain();
      chk("bad_err", 32'(err_count), 32'd2);
      chk("bad_rx", 32'(rx_count), 32'd0);
      chk("bad_sum", lat_sum, 32'd0);

      // Timestamp 0xFFFE popped at cycle_cnt=3
      do_reset();
      idle(1);
      pkt_in = {1'b1, 16'hFFFE, 16'd1, 16'd3};
      tick(a);
      chk("wrap_acc", 32'(a), 32'd1);
      idle(2);
      chk("wrap_max", 32'(lat_max), 32'd5);
      chk("wrap_sum", lat_sum, 32'd5);
      chk("wrap_src", 32'(last_src), 32'd1);

      // done after EXP good packets; the next one is an error
      do_reset();
      for (int i = 0; i < 4; i++) send(tb_cyc, 16'(i), 16'd3);
      drain();
      chk("done_set", 32'(done), 32'd1);
      chk("done_rx", 32'(rx_count), 32'd3);
      chk("done_err", 32'(err_count), 32'd1);
      chk("done_src", 32'(last_src), 32'd2);

      // Back-to-back burst fills the FIFO; pops stay two cycles apart; nothing is lost
      do_reset();
      saw_full = 1'b0;
      for (int i = 0; i < 8; i++) send(tb_cyc, 16'(i % 4), 16'd3);
      drain();
      chk("burst_full", 32'(saw_full), 32'd1);
      chk("burst_pops", 32'(pop_cyc.size()), 32'd8);
      for (int i = 1; i < pop_cyc.size(); i++)
         chk("burst_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
      chk("burst_total", 32'(rx_count) + 32'(err_count), 32'd8);

      // Reset with packets still buffered discards them
      do_reset();
      for (int i = 0; i < 4; i++) send(tb_cyc, 16'd1, 16'd3);
      pkt_in = '0;
      rst = 1'b1;
      tick(a);
      chk("mid_rst_rx", 32'(rx_count), 32'd0);
      chk("mid_rst_err", 32'(err_count), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready), 32'd1);
      rst = 1'b0;
      idle(10);
      chk("post_rst_total", 32'(rx_count) + 32'(err_count), 32'd0);
      chk("post_rst_sum", lat_sum, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
